// File: rtl/div_seq_if.sv
// div_seq_if: EX-stage divide request/response bundle.
// master = EX initiator, slave = div_seq responder.
// start_i/annul_i/signed_div_i/opdata1_i/opdata2_i : request
// result_o {rem, quo} and ready_o : response
interface div_seq_if #(
    parameter int DATA_W = 32
) ();
    logic                  start_i;
    logic                  annul_i;
    logic                  signed_div_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;

    modport master (
        output start_i,
        output annul_i,
        output signed_div_i,
        output opdata1_i,
        output opdata2_i,
        input  result_o,
        input  ready_o
    );

    modport slave (
        input  start_i,
        input  annul_i,
        input  signed_div_i,
        input  opdata1_i,
        input  opdata2_i,
        output result_o,
        output ready_o
    );
endinterface

// File: rtl/div_seq.sv
// div_seq: iterative radix-2 restoring divider, one quotient bit per cycle.
// Ports: clk, resetn (async active-low), bus (div_seq_if.slave).
module div_seq #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic       clk,
    input  logic       resetn,
    div_seq_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIVZERO,
        S_ON,
        S_END
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [DATA_W-1:0]     r_quo;
    logic [DATA_W-1:0]     r_rem;
    logic [DATA_W-1:0]     r_dvs;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_qneg;
    logic                  r_rneg;
    logic [2*DATA_W-1:0]   r_result;
    logic                  r_ready;

    logic                  w_neg1;
    logic                  w_neg2;
    logic [DATA_W-1:0]     w_abs1;
    logic [DATA_W-1:0]     w_abs2;
    logic [DATA_W:0]       w_sh;
    logic [DATA_W:0]       w_diff;
    logic                  w_qbit;
    logic [DATA_W-1:0]     w_rem_step;
    logic [DATA_W-1:0]     w_quo_step;
    logic [DATA_W-1:0]     w_rem_fix;
    logic [DATA_W-1:0]     w_quo_fix;
    logic                  w_last;
    logic                  w_go;

    // Operand magnitudes; raw values for unsigned.
    assign w_neg1 = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
    assign w_neg2 = bus.signed_div_i & bus.opdata2_i[DATA_W-1];
    assign w_abs1 = w_neg1 ? -bus.opdata1_i : bus.opdata1_i;
    assign w_abs2 = w_neg2 ? -bus.opdata2_i : bus.opdata2_i;

    // Partial remainder is always below the divisor, so the shifted
    // value fits in DATA_W+1 bits and the borrow bit decides the step.
    assign w_sh       = {r_rem, r_quo[DATA_W-1]};
    assign w_diff     = w_sh - {1'b0, r_dvs};
    assign w_qbit     = ~w_diff[DATA_W];
    assign w_rem_step = w_qbit ? w_diff[DATA_W-1:0] : w_sh[DATA_W-1:0];
    assign w_quo_step = {r_quo[DATA_W-2:0], w_qbit};
    assign w_quo_fix  = r_qneg ? -w_quo_step : w_quo_step;
    assign w_rem_fix  = r_rneg ? -w_rem_step : w_rem_step;

    assign w_last = (r_cnt == CNT_W'(DATA_W - 1));
    assign w_go   = bus.start_i & ~bus.annul_i;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_go) begin
                    if (bus.opdata2_i == '0) begin
                        w_state_nxt = S_DIVZERO;
                    end else begin
                        w_state_nxt = S_ON;
                    end
                end
            end
            S_DIVZERO: begin
                w_state_nxt = S_END;
            end
            S_ON: begin
                if (!w_go) begin
                    w_state_nxt = S_IDLE;
                end else if (w_last) begin
                    w_state_nxt = S_END;
                end
            end
            S_END: begin
                if (!w_go) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_quo    <= '0;
            r_rem    <= '0;
            r_dvs    <= '0;
            r_cnt    <= '0;
            r_qneg   <= 1'b0;
            r_rneg   <= 1'b0;
            r_result <= '0;
            r_ready  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_state_nxt == S_ON) begin
                        r_quo  <= w_abs1;
                        r_dvs  <= w_abs2;
                        r_rem  <= '0;
                        r_cnt  <= '0;
                        r_qneg <= w_neg1 ^ w_neg2;
                        r_rneg <= w_neg1;
                    end
                end
                S_DIVZERO: begin
                    r_result <= '0;
                    r_ready  <= 1'b1;
                end
                S_ON: begin
                    if (w_state_nxt == S_ON) begin
                        r_quo <= w_quo_step;
                        r_rem <= w_rem_step;
                        r_cnt <= r_cnt + CNT_W'(1);
                    end else if (w_state_nxt == S_END) begin
                        // Final step folds in the sign correction.
                        r_result <= {w_rem_fix, w_quo_fix};
                        r_ready  <= 1'b1;
                    end
                end
                S_END: begin
                    if (w_state_nxt != S_END) begin
                        r_result <= '0;
                        r_ready  <= 1'b0;
                    end
                end
                default: begin
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign bus.result_o = r_result;
    assign bus.ready_o  = r_ready;

endmodule
